// File: rtl/ttfs_output_recorder.sv
// First-spike recorder for the TTFS output layer: per-neuron first-spike ticks,
// earliest-neuron winner tracking, classification interrupt, OBI register port.
package ttfs_rec_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_rsp_t;
endpackage

// One output-neuron slot: holds the tick of its first spike since the last arm.
module ttfs_rec_entry (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       clr_i,
  input  logic       cap_i,
  input  logic [7:0] tick_i,
  output logic       vld_o,
  output logic [7:0] tick_o
);
  logic       vld_d, vld_q;
  logic [7:0] tick_d, tick_q;

  always_comb begin
    vld_d  = vld_q;
    tick_d = tick_q;
    if (clr_i) begin
      vld_d  = 1'b0;
      tick_d = '0;
    end else if (cap_i) begin
      vld_d  = 1'b1;
      tick_d = tick_i;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vld_q  <= 1'b0;
      tick_q <= '0;
    end else begin
      vld_q  <= vld_d;
      tick_q <= tick_d;
    end
  end

  assign vld_o  = vld_q;
  assign tick_o = tick_q;
endmodule

module ttfs_output_recorder #(
  parameter int  N            = 256,
  parameter int  NUM_OUT      = 10,
  parameter int  OUT_BASE     = 246,
  parameter int  TIMEOUT_TICK = 255,
  parameter type req_t        = ttfs_rec_pkg::obi_req_t,
  parameter type rsp_t        = ttfs_rec_pkg::obi_rsp_t
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 spike_i,
  input  logic [$clog2(N)-1:0] count_i,
  input  logic [7:0]           tick_i,
  input  logic                 next_tick_i,
  input  req_t                 recorder_slave_req_i,
  output rsp_t                 recorder_slave_resp_o,
  output logic                 intr_classified_o
);
  localparam int IW = $clog2(N);
  localparam int LW = 5;

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_e;

  state_e                     state_d, state_q;
  logic                       run_mode_d, run_mode_q;
  logic                       ctrl_mode_d, ctrl_mode_q;
  logic                       done_d, done_q;
  logic                       timeout_d, timeout_q;
  logic                       wv_d, wv_q;
  logic [LW-1:0]              widx_d, widx_q;
  logic [7:0]                 wtick_d, wtick_q;
  logic                       rvalid_d, rvalid_q;
  logic [31:0]                rdata_d, rdata_q;

  logic [NUM_OUT-1:0]         ent_vld;
  logic [NUM_OUT-1:0][7:0]    ent_tick;
  logic [NUM_OUT-1:0]         hit, cap_vec;
  logic                       in_range, cap, all_vld, timeout_ev;
  logic [LW-1:0]              e;
  logic [31:0]                rd_mux;

  logic        req, we;
  logic [5:0]  word;
  logic [31:0] wdata;
  logic        arm, ctrl_wr, w1c;

  assign req   = recorder_slave_req_i.req;
  assign we    = recorder_slave_req_i.we;
  assign word  = recorder_slave_req_i.addr[7:2];
  assign wdata = recorder_slave_req_i.wdata;

  assign ctrl_wr = req && we && (word == 6'd0);
  assign arm     = ctrl_wr && wdata[0];
  assign w1c     = req && we && (word == 6'd1) && wdata[1];

  // Range check in IW+1 bits so OUT_BASE+NUM_OUT == N does not wrap.
  assign in_range = ({1'b0, count_i} >= (IW+1)'(OUT_BASE)) &&
                    ({1'b0, count_i} <  (IW+1)'(OUT_BASE + NUM_OUT));
  assign e        = LW'(count_i - IW'(OUT_BASE));

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_OUT; i++) hit[i] = in_range && (e == LW'(i));
  end

  // Arm has priority over a coincident spike; only not-yet-valid slots capture.
  assign cap        = (state_q == ARMED) && spike_i && !arm && |(hit & ~ent_vld);
  assign cap_vec    = cap ? (hit & ~ent_vld) : '0;
  assign all_vld    = &(ent_vld | cap_vec);
  assign timeout_ev = next_tick_i && (tick_i == 8'(TIMEOUT_TICK));

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_ent
    ttfs_rec_entry u_ent (
      .CLK    (CLK),
      .RSTN   (RSTN),
      .clr_i  (arm),
      .cap_i  (cap_vec[g]),
      .tick_i (tick_i),
      .vld_o  (ent_vld[g]),
      .tick_o (ent_tick[g])
    );
  end

  always_comb begin
    rd_mux = '0;
    case (word)
      6'd0:    rd_mux = {30'd0, ctrl_mode_q, 1'b0};
      6'd1:    rd_mux = {8'd0, wtick_q, 3'd0, widx_q, 4'd0,
                         wv_q, timeout_q, done_q, (state_q == ARMED)};
      6'd2:    rd_mux = 32'(ent_vld);
      default: begin
        for (int i = 0; i < NUM_OUT; i++)
          if (word == 6'(16 + i)) rd_mux = {ent_vld[i], 23'd0, ent_tick[i]};
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    run_mode_d  = run_mode_q;
    ctrl_mode_d = ctrl_mode_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    wv_d        = wv_q;
    widx_d      = widx_q;
    wtick_d     = wtick_q;
    rvalid_d    = req;
    rdata_d     = (req && !we) ? rd_mux : 32'd0;

    if (ctrl_wr) ctrl_mode_d = wdata[1];

    if (arm) begin
      state_d    = ARMED;
      run_mode_d = wdata[1];
      done_d     = 1'b0;
      timeout_d  = 1'b0;
      wv_d       = 1'b0;
      widx_d     = '0;
      wtick_d    = '0;
    end else begin
      if (w1c) done_d = 1'b0;
      if (state_q == ARMED) begin
        if (cap && (!wv_q || (tick_i < wtick_q) ||
                    ((tick_i == wtick_q) && (e < widx_q)))) begin
          wv_d    = 1'b1;
          widx_d  = e;
          wtick_d = tick_i;
        end
        if (!run_mode_q) begin
          if (cap) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else if (timeout_ev) begin
          state_d   = DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else if (all_vld) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= IDLE;
      run_mode_q  <= 1'b0;
      ctrl_mode_q <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      wv_q        <= 1'b0;
      widx_q      <= '0;
      wtick_q     <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      run_mode_q  <= run_mode_d;
      ctrl_mode_q <= ctrl_mode_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      wv_q        <= wv_d;
      widx_q      <= widx_d;
      wtick_q     <= wtick_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign recorder_slave_resp_o.gnt    = req;
  assign recorder_slave_resp_o.rvalid = rvalid_q;
  assign recorder_slave_resp_o.rdata  = rdata_q;
  assign intr_classified_o            = done_q;

  logic unused_bits;
  assign unused_bits = ^{recorder_slave_req_i.addr[31:8],
                         recorder_slave_req_i.addr[1:0], wdata[31:2]};
endmodule
